// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing for the byte-to-serial feeder of the "1101" detector.
package bit_serializer_pkg;

   localparam int unsigned DEF_W = 8;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned GAP_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Byte-in / bit-out bundle between an upstream producer and bit_serializer.
interface bit_serializer_if
   import bit_serializer_pkg::*;
#(
   parameter int unsigned W = DEF_W
) ();

   logic             i_byte_valid;
   logic [W-1:0]     i_byte;
   logic             o_byte_ready;
   logic             i_stall;
   logic             i_flush;
   logic             o_valid;
   logic             o_data;
   logic             o_last;
   logic             o_busy;
   logic [CNT_W-1:0] o_byte_cnt;

   modport master (
      output i_byte_valid, i_byte, i_stall, i_flush,
      input  o_byte_ready, o_valid, o_data, o_last, o_busy, o_byte_cnt
   );

   modport slave (
      input  i_byte_valid, i_byte, i_stall, i_flush,
      output o_byte_ready, o_valid, o_data, o_last, o_busy, o_byte_cnt
   );

endinterface

// File: rtl/bit_serializer_hold_reg.sv
// One-entry valid/ready holding register with synchronous flush.
// Ready is registered and equals the inverse of the next occupancy.
module serial_hold_reg
   import bit_serializer_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_flush,
   input  logic         i_wr_valid,
   input  logic [W-1:0] i_wr_data,
   output logic         o_wr_ready,
   input  logic         i_rd_en,
   output logic         o_rd_valid,
   output logic [W-1:0] o_rd_data
);

   logic         r_vld;
   logic         r_ready;
   logic [W-1:0] r_data;
   logic         w_wr_fire;
   logic         w_vld_nxt;

   // Flush beats a same-cycle write; a write can only happen while empty.
   assign w_wr_fire = i_wr_valid & r_ready & ~i_flush;
   assign w_vld_nxt = i_flush   ? 1'b0 :
                      w_wr_fire ? 1'b1 :
                      i_rd_en   ? 1'b0 : r_vld;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld   <= 1'b0;
         r_ready <= 1'b0;
         r_data  <= '0;
      end else begin
         r_vld   <= w_vld_nxt;
         r_ready <= ~w_vld_nxt;
         if (w_wr_fire) r_data <= i_wr_data;
      end
   end

   assign o_wr_ready = r_ready;
   assign o_rd_valid = r_vld;
   assign o_rd_data  = r_data;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: bytes in over valid/ready, one valid-qualified bit per cycle out,
// with optional inter-byte gap, downstream stall and synchronous flush.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned W         = DEF_W,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned GAP       = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   bit_serializer_if.slave   bus
);

   localparam int unsigned          IDX_W    = $clog2(W);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(W - 1);
   localparam logic [IDX_W-1:0]     PEN_IDX  = IDX_W'(W - 2);
   localparam bit                   HAS_GAP  = (GAP > 0);
   localparam logic [GAP_W-1:0]     GAP_LD   = HAS_GAP ? GAP_W'(GAP - 1) : '0;

   state_t           r_state;
   logic [W-1:0]     r_shift;
   logic [IDX_W-1:0] r_bit_idx;
   logic [GAP_W-1:0] r_gapcnt;
   logic             r_valid;
   logic             r_data;
   logic             r_last;
   logic [CNT_W-1:0] r_byte_cnt;

   logic             w_hold_vld;
   logic [W-1:0]     w_hold_data;
   logic             w_hold_ready;
   logic             w_byte_done;
   logic             w_slot_free;
   logic             w_load;
   logic             w_first_bit;
   logic [W-1:0]     w_shift_nxt;
   logic             w_next_bit;

   serial_hold_reg #(.W(W)) u_hold (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_flush    (bus.i_flush),
      .i_wr_valid (bus.i_byte_valid),
      .i_wr_data  (bus.i_byte),
      .o_wr_ready (w_hold_ready),
      .i_rd_en    (w_load),
      .o_rd_valid (w_hold_vld),
      .o_rd_data  (w_hold_data)
   );

   // A byte finishes when its last bit has been presented and is not stalled.
   assign w_byte_done = (r_state == ST_SHIFT) & r_valid & (r_bit_idx == LAST_IDX)
                        & ~bus.i_stall & ~bus.i_flush;
   assign w_slot_free = (r_state == ST_IDLE)
                        | ((r_state == ST_GAP) & (r_gapcnt == '0))
                        | (w_byte_done & ~HAS_GAP);
   assign w_load      = w_hold_vld & w_slot_free & ~bus.i_stall & ~bus.i_flush;

   assign w_first_bit = MSB_FIRST ? w_hold_data[W-1] : w_hold_data[0];
   assign w_shift_nxt = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
   assign w_next_bit  = MSB_FIRST ? w_shift_nxt[W-1] : w_shift_nxt[0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_gapcnt   <= '0;
         r_valid    <= 1'b0;
         r_data     <= 1'b0;
         r_last     <= 1'b0;
         r_byte_cnt <= '0;
      end else if (bus.i_flush) begin
         r_state  <= ST_IDLE;
         r_gapcnt <= '0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
      end else begin
         if (w_byte_done) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
         if (w_load) begin
            r_state   <= ST_SHIFT;
            r_shift   <= w_hold_data;
            r_data    <= w_first_bit;
            r_bit_idx <= '0;
            r_valid   <= 1'b1;
            r_last    <= 1'b0;
         end else begin
            case (r_state)
               ST_SHIFT: begin
                  if (bus.i_stall) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                  end else if (!r_valid) begin
                     // Resume after a stall: re-present the held bit.
                     r_valid <= 1'b1;
                     r_last  <= (r_bit_idx == LAST_IDX);
                  end else if (r_bit_idx != LAST_IDX) begin
                     r_shift   <= w_shift_nxt;
                     r_data    <= w_next_bit;
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                     r_last    <= (r_bit_idx == PEN_IDX);
                  end else if (HAS_GAP) begin
                     r_state  <= ST_GAP;
                     r_gapcnt <= GAP_LD;
                     r_valid  <= 1'b0;
                     r_last   <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                  end
               end
               ST_GAP: begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  if (r_gapcnt != '0) r_gapcnt <= r_gapcnt - GAP_W'(1);
                  else                r_state  <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.o_byte_ready = w_hold_ready;
   assign bus.o_valid      = r_valid;
   assign bus.o_data       = r_data;
   assign bus.o_last       = r_last;
   assign bus.o_busy       = (r_state != ST_IDLE) | w_hold_vld;
   assign bus.o_byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed scenarios plus random traffic against a bit-queue reference model.
// Instance a: W=8 MSB-first no gap; instance b: W=8 LSB-first GAP=2.
module tb_bit_serializer;

   localparam int unsigned W  = 8;
   localparam int unsigned HN = 2048;
   localparam int unsigned QN = 256;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   bit_serializer_if #(.W(W)) if_a ();
   bit_serializer_if #(.W(W)) if_b ();

   bit_serializer #(.W(W), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
      .i_clk (clk), .i_rst_n (rst_n), .bus (if_a.slave));
   bit_serializer #(.W(W), .MSB_FIRST(1'b0), .GAP(2)) dut_b (
      .i_clk (clk), .i_rst_n (rst_n), .bus (if_b.slave));

   logic         bv [2];
   logic [W-1:0] bd [2];
   logic         st [2];
   logic         fl [2];

   assign if_a.i_byte_valid = bv[0];
   assign if_a.i_byte       = bd[0];
   assign if_a.i_stall      = st[0];
   assign if_a.i_flush      = fl[0];
   assign if_b.i_byte_valid = bv[1];
   assign if_b.i_byte       = bd[1];
   assign if_b.i_stall      = st[1];
   assign if_b.i_flush      = fl[1];

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: expected serial bits as {bit, is_last} in a ring per instance.
   logic [1:0] eq [2][QN];
   int         rp [2];
   int         wp [2];
   int         exp_cnt [2];
   bit         pres [2];
   int         hs_n [2];
   int         hs_at [2];
   int         tcnt;
   logic       hv [2][HN];
   logic       hd [2][HN];
   logic       hl [2][HN];
   logic       hr [2][HN];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic get_out(input int id, output logic v, output logic d, output logic l,
                          output logic r, output logic b, output logic [7:0] c);
      if (id == 0) begin
         v = if_a.o_valid; d = if_a.o_data; l = if_a.o_last;
         r = if_a.o_byte_ready; b = if_a.o_busy; c = if_a.o_byte_cnt;
      end else begin
         v = if_b.o_valid; d = if_b.o_data; l = if_b.o_last;
         r = if_b.o_byte_ready; b = if_b.o_busy; c = if_b.o_byte_cnt;
      end
   endtask

   task automatic reset_model();
      for (int id = 0; id < 2; id++) begin
         rp[id] = 0; wp[id] = 0; exp_cnt[id] = 0; pres[id] = 1'b0;
      end
   endtask

   task automatic push_byte(input int id, input logic [W-1:0] b);
      int unsigned bi;
      for (int k = 0; k < int'(W); k++) begin
         bi = (id == 0) ? (W - 1 - k) : k;
         eq[id][wp[id] % QN] = {b[bi], (k == int'(W) - 1)};
         wp[id]++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      logic v, d, l, r, b;
      logic [7:0] c;
      for (int id = 0; id < 2; id++) begin
         get_out(id, v, d, l, r, b, c);
         chk($sformatf("%s_valid[%0d]", tag, id), v, 0);
         chk($sformatf("%s_data[%0d]", tag, id), d, 0);
         chk($sformatf("%s_last[%0d]", tag, id), l, 0);
         chk($sformatf("%s_ready[%0d]", tag, id), r, 0);
         chk($sformatf("%s_busy[%0d]", tag, id), b, 0);
         chk($sformatf("%s_cnt[%0d]", tag, id), c, 0);
      end
   endtask

   // One clock: capture handshakes before the edge, advance the model, check #1 after.
   task automatic step();
      logic hs [2];
      logic s_st [2];
      logic s_fl [2];
      logic v, d, l, r, b;
      logic [7:0] c;
      for (int id = 0; id < 2; id++) begin
         get_out(id, v, d, l, r, b, c);
         hs[id]   = bv[id] & r;
         s_st[id] = st[id];
         s_fl[id] = fl[id];
      end
      @(posedge clk);
      #1;
      tcnt++;
      for (int id = 0; id < 2; id++) begin
         if (s_fl[id]) begin
            rp[id] = wp[id];
         end else begin
            if (pres[id] && !s_st[id] && rp[id] != wp[id]) begin
               if (eq[id][rp[id] % QN][0]) exp_cnt[id]++;
               rp[id]++;
            end
            if (hs[id] === 1'b1) begin
               push_byte(id, bd[id]);
               hs_n[id]++;
               hs_at[id] = tcnt;
            end
         end
         get_out(id, v, d, l, r, b, c);
         if (tcnt < int'(HN)) begin
            hv[id][tcnt] = v; hd[id][tcnt] = d; hl[id][tcnt] = l; hr[id][tcnt] = r;
         end
         chk($sformatf("byte_cnt[%0d]@%0d", id, tcnt), c, 8'(exp_cnt[id]));
         if (v === 1'b1) begin
            chk($sformatf("bit_expected[%0d]@%0d", id, tcnt), (rp[id] != wp[id]), 1);
            if (rp[id] != wp[id]) begin
               chk($sformatf("data[%0d]@%0d", id, tcnt), d, eq[id][rp[id] % QN][1]);
               chk($sformatf("last[%0d]@%0d", id, tcnt), l, eq[id][rp[id] % QN][0]);
            end
         end
         pres[id] = (v === 1'b1);
      end
   endtask

   task automatic wait_hs(input int id, input int target);
      for (int i = 0; i < 20 && hs_n[id] < target; i++) step();
      chk($sformatf("handshake[%0d]#%0d", id, target), hs_n[id], target);
   endtask

   task automatic chk_hist(input string tag, input int id, input int t,
                           input logic v, input logic d, input logic l);
      chk($sformatf("%s_valid@%0d", tag, t), hv[id][t], v);
      if (v) begin
         chk($sformatf("%s_data@%0d", tag, t), hd[id][t], d);
         chk($sformatf("%s_last@%0d", tag, t), hl[id][t], l);
      end
   endtask

   initial begin
      logic v, d, l, r, b;
      logic [7:0]  c;
      logic [7:0]  p;
      logic [7:0]  q;
      logic [15:0] p16;
      int e, e1, base;

      tcnt = 0;
      for (int id = 0; id < 2; id++) begin
         bv[id] = 1'b0; bd[id] = '0; st[id] = 1'b0; fl[id] = 1'b0;
         hs_n[id] = 0; hs_at[id] = 0;
      end
      reset_model();

      // Reset values, then ready rises on the first edge after release.
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("in_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int id = 0; id < 2; id++) begin
         get_out(id, v, d, l, r, b, c);
         chk($sformatf("ready_before_edge[%0d]", id), r, 0);
      end
      step();
      for (int id = 0; id < 2; id++) begin
         get_out(id, v, d, l, r, b, c);
         chk($sformatf("ready_after_release[%0d]", id), r, 1);
      end

      // Single byte 6D, MSB first: 0,1,1,0,1,1,0,1.
      p = 8'h6D;
      bv[0] = 1'b1; bd[0] = p;
      wait_hs(0, 1);
      bv[0] = 1'b0;
      e = hs_at[0];
      repeat (10) step();
      chk_hist("t1", 0, e, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) chk_hist("t1", 0, e + k, 1'b1, p[8 - k], (k == 8));
      chk_hist("t1", 0, e + 9, 1'b0, 1'b0, 1'b0);
      get_out(0, v, d, l, r, b, c);
      chk("t1_cnt", c, 1);
      chk("t1_busy", b, 0);

      // Back-to-back DD, DD: 16 bits without bubble.
      p16 = 16'hDDDD;
      bv[0] = 1'b1; bd[0] = 8'hDD;
      wait_hs(0, 2);
      e1 = hs_at[0];
      wait_hs(0, 3);
      bv[0] = 1'b0;
      chk("t2_hs_spacing", hs_at[0] - e1, 2);
      repeat (18) step();
      for (int k = 1; k <= 16; k++)
         chk_hist("t2", 0, e1 + k, 1'b1, p16[16 - k], (k == 8 || k == 16));
      chk_hist("t2", 0, e1 + 17, 1'b0, 1'b0, 1'b0);
      chk("t2_ready_full_a", hr[0][e1 + 2], 0);
      chk("t2_ready_full_b", hr[0][e1 + 8], 0);
      chk("t2_ready_refill", hr[0][e1 + 9], 1);

      // B4 with a 3-cycle stall after bit 3; bit 3 is re-presented on resume.
      p = 8'hB4;
      bv[0] = 1'b1; bd[0] = p;
      wait_hs(0, 4);
      bv[0] = 1'b0;
      e = hs_at[0];
      repeat (3) step();
      st[0] = 1'b1;
      repeat (3) step();
      st[0] = 1'b0;
      repeat (8) step();
      for (int k = 1; k <= 3; k++) chk_hist("t3", 0, e + k, 1'b1, p[8 - k], 1'b0);
      for (int k = 4; k <= 6; k++) begin
         chk_hist("t3_stall", 0, e + k, 1'b0, 1'b0, 1'b0);
         chk($sformatf("t3_frozen@%0d", k), hd[0][e + k], p[5]);
      end
      for (int j = 3; j <= 8; j++) chk_hist("t3_resume", 0, e + 4 + j, 1'b1, p[8 - j], (j == 8));
      chk_hist("t3", 0, e + 13, 1'b0, 1'b0, 1'b0);
      get_out(0, v, d, l, r, b, c);
      chk("t3_cnt", c, 4);

      // Instance b: LSB first, two idle cycles between 0B and 01.
      p = 8'h0B; q = 8'h01;
      bv[1] = 1'b1; bd[1] = p;
      wait_hs(1, 1);
      e1 = hs_at[1];
      bd[1] = q;
      wait_hs(1, 2);
      bv[1] = 1'b0;
      repeat (22) step();
      for (int k = 1; k <= 8; k++) chk_hist("t4a", 1, e1 + k, 1'b1, p[k - 1], (k == 8));
      chk_hist("t4_gap", 1, e1 + 9, 1'b0, 1'b0, 1'b0);
      chk_hist("t4_gap", 1, e1 + 10, 1'b0, 1'b0, 1'b0);
      for (int k = 11; k <= 18; k++) chk_hist("t4b", 1, e1 + k, 1'b1, q[k - 11], (k == 18));
      chk_hist("t4", 1, e1 + 19, 1'b0, 1'b0, 1'b0);
      get_out(1, v, d, l, r, b, c);
      chk("t4_cnt", c, 2);

      // Flush at bit 5 of FF with 0F held: nothing further, count unchanged.
      bv[0] = 1'b1; bd[0] = 8'hFF;
      wait_hs(0, 5);
      e1 = hs_at[0];
      bd[0] = 8'h0F;
      wait_hs(0, 6);
      bv[0] = 1'b0;
      for (int i = 0; i < 10 && tcnt < e1 + 5; i++) step();
      chk_hist("t5_bit5", 0, e1 + 5, 1'b1, 1'b1, 1'b0);
      fl[0] = 1'b1;
      step();
      fl[0] = 1'b0;
      chk("t5_ready", hr[0][e1 + 6], 1);
      chk("t5_last", hl[0][e1 + 6], 0);
      repeat (12) step();
      for (int t = e1 + 6; t <= e1 + 17; t++) chk($sformatf("t5_quiet@%0d", t), hv[0][t], 0);
      get_out(0, v, d, l, r, b, c);
      chk("t5_cnt", c, 4);
      chk("t5_busy", b, 0);

      // Flush beats a simultaneous handshake.
      bv[0] = 1'b1; bd[0] = 8'hA5; fl[0] = 1'b1;
      step();
      bv[0] = 1'b0; fl[0] = 1'b0;
      e = tcnt;
      repeat (12) step();
      for (int t = e; t <= e + 12; t++) chk($sformatf("t5b_quiet@%0d", t), hv[0][t], 0);
      get_out(0, v, d, l, r, b, c);
      chk("t5b_busy", b, 0);
      chk("t5b_ready", r, 1);

      // Asynchronous reset in the middle of a byte.
      bv[0] = 1'b1; bd[0] = 8'hE7;
      wait_hs(0, 7);
      bv[0] = 1'b0;
      repeat (4) step();
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      reset_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      get_out(0, v, d, l, r, b, c);
      chk("t6_ready_before_edge", r, 0);
      step();
      e = tcnt;
      get_out(0, v, d, l, r, b, c);
      chk("t6_ready_after_edge", r, 1);
      repeat (12) step();
      for (int t = e; t <= e + 12; t++) chk($sformatf("t6_quiet@%0d", t), hv[0][t], 0);

      // Random traffic on both instances against the queue model.
      for (int i = 0; i < 600; i++) begin
         for (int id = 0; id < 2; id++) begin
            bv[id] = ($urandom_range(0, 3) != 0);
            bd[id] = W'($urandom);
            st[id] = ($urandom_range(0, 9) == 0);
            fl[id] = ($urandom_range(0, 49) == 0);
         end
         step();
      end
      for (int id = 0; id < 2; id++) begin
         bv[id] = 1'b0; st[id] = 1'b0; fl[id] = 1'b0;
      end
      for (int i = 0; i < 60 && (rp[0] != wp[0] || rp[1] != wp[1]
                                 || if_a.o_busy !== 1'b0 || if_b.o_busy !== 1'b0); i++)
         step();
      step();
      for (int id = 0; id < 2; id++) begin
         get_out(id, v, d, l, r, b, c);
         chk($sformatf("drain_pending[%0d]", id), wp[id] - rp[id], 0);
         chk($sformatf("drain_busy[%0d]", id), b, 0);
         chk($sformatf("drain_valid[%0d]", id), v, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
